// File: rtl/nn_pkg.sv
// Shared constants and types for the neuron datapath and the sigmoid LUT stage.
package nn_pkg;

  localparam int LUT_DEPTH = 500;
  localparam int LUT_HALF  = LUT_DEPTH / 2;
  localparam int FRAC_BITS = 8;

  typedef logic signed [63:0] lut_idx_t;

  typedef enum logic [1:0] {
    ACC = 2'd0,
    QNT = 2'd1,
    OUT = 2'd2
  } mac_state_e;

endpackage

// File: rtl/neuron_mac_quant_if.sv
// Beat input stream and quantised-index output handshake of the neuron MAC stage.
interface neuron_mac_quant_if #(
  parameter int DATA_W = 16
);
  import nn_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_x;
  logic [DATA_W-1:0] in_w;
  logic [DATA_W-1:0] in_bias;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  lut_idx_t          out_idx;
  logic              err_len;

  // Producer of beats / consumer of indices.
  modport master (
    output in_valid, in_x, in_w, in_bias, in_last, out_ready,
    input  in_ready, out_valid, out_idx, err_len
  );

  // The MAC stage itself.
  modport slave (
    input  in_valid, in_x, in_w, in_bias, in_last, out_ready,
    output in_ready, out_valid, out_idx, err_len
  );

endinterface

// File: rtl/idx_saturate.sv
// Converts a full-precision accumulator into a clamped, sign-extended LUT index.
module idx_saturate
  import nn_pkg::*;
#(
  parameter int ACC_W = 43,
  parameter int SHIFT = 12,
  parameter int HALF  = 250
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output lut_idx_t                idx_o
);

  localparam logic signed [ACC_W-1:0] HI = ACC_W'(HALF - 1);
  localparam logic signed [ACC_W-1:0] LO = ACC_W'(-HALF);

  logic signed [ACC_W-1:0] q;
  logic signed [ACC_W-1:0] clamped;

  // Floor-shift to index resolution, then clamp into the LUT address range.
  always_comb begin
    q       = acc_i >>> SHIFT;
    clamped = q;
    if (q > HI) begin
      clamped = HI;
    end else if (q < LO) begin
      clamped = LO;
    end
    idx_o = 64'(clamped);
  end

endmodule

// File: rtl/neuron_mac_quant.sv
// Single-neuron multiply-accumulate with bias, quantised to a sigmoid LUT index.
module neuron_mac_quant #(
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = nn_pkg::FRAC_BITS,
  parameter int MAX_N     = 1024,
  parameter int IDX_SHIFT = 12,
  parameter int LUT_HALF  = nn_pkg::LUT_HALF
) (
  input  logic              Clk,
  input  logic              Reset,
  neuron_mac_quant_if.slave bus
);
  import nn_pkg::*;

  // Wide enough that MAX_N full-scale products plus bias cannot overflow.
  localparam int ACC_W = 2 * DATA_W + $clog2(MAX_N) + 1;
  localparam int CNT_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_N - 1);

  mac_state_e              state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
  logic                    first_q, first_d;
  logic                    out_valid_q, out_valid_d;
  lut_idx_t                out_idx_q, out_idx_d;
  logic                    err_len_q, err_len_d;

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    bias_ext;
  logic                       beat;
  lut_idx_t                   idx_sat;

  idx_saturate #(
    .ACC_W (ACC_W),
    .SHIFT (IDX_SHIFT),
    .HALF  (LUT_HALF)
  ) u_sat (
    .acc_i (acc_q),
    .idx_o (idx_sat)
  );

  // Full-precision product and bias aligned to the product's 2*FRAC_BITS scale.
  always_comb begin
    prod     = $signed(bus.in_x) * $signed(bus.in_w);
    prod_ext = ACC_W'(prod);
    bias_ext = ACC_W'($signed(bus.in_bias)) <<< FRAC_BITS;
    beat     = bus.in_valid && (state_q == ACC);
  end

  // Next-state logic: accumulate beats, quantise once, hold result until taken.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    beat_cnt_d  = beat_cnt_q;
    first_d     = first_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    err_len_d   = 1'b0;
    case (state_q)
      ACC: begin
        if (beat) begin
          acc_d      = (first_q ? bias_ext : acc_q) + prod_ext;
          beat_cnt_d = beat_cnt_q + 1'b1;
          first_d    = 1'b0;
          if (bus.in_last || (beat_cnt_q == LAST_CNT)) begin
            state_d = QNT;
          end
          // Neuron ran out of beats without in_last: close it anyway and flag it.
          if ((beat_cnt_q == LAST_CNT) && !bus.in_last) begin
            err_len_d = 1'b1;
          end
        end
      end
      QNT: begin
        out_idx_d   = idx_sat;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          beat_cnt_d  = '0;
          first_d     = 1'b1;
          state_d     = ACC;
        end
      end
      default: begin
        state_d = ACC;
      end
    endcase
  end

  // State registers; reset drops any partial neuron.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ACC;
      acc_q       <= '0;
      beat_cnt_q  <= '0;
      first_q     <= 1'b1;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      err_len_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      beat_cnt_q  <= beat_cnt_d;
      first_q     <= first_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      err_len_q   <= err_len_d;
    end
  end

  assign bus.in_ready  = (state_q == ACC);
  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.err_len   = err_len_q;

endmodule

// File: tb/tb_neuron_mac_quant.sv
// Directed checks of the neuron MAC/quantiser with hand-computed indices.
module tb_neuron_mac_quant;
  import nn_pkg::*;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 Clk = ~Clk;

  neuron_mac_quant_if #(.DATA_W(16)) if0 ();
  neuron_mac_quant_if #(.DATA_W(16)) if1 ();

  neuron_mac_quant #(.MAX_N(1024)) dut0 (.Clk(Clk), .Reset(Reset), .bus(if0.slave));
  neuron_mac_quant #(.MAX_N(4))    dut1 (.Clk(Clk), .Reset(Reset), .bus(if1.slave));

  task automatic beat0(input logic [15:0] x, input logic [15:0] w,
                       input logic [15:0] b, input logic last);
    if0.in_valid = 1'b1;
    if0.in_x     = x;
    if0.in_w     = w;
    if0.in_bias  = b;
    if0.in_last  = last;
    @(posedge Clk); #1;
    if0.in_valid = 1'b0;
    if0.in_last  = 1'b0;
  endtask

  task automatic beat1(input logic [15:0] x, input logic [15:0] w,
                       input logic [15:0] b, input logic last);
    if1.in_valid = 1'b1;
    if1.in_x     = x;
    if1.in_w     = w;
    if1.in_bias  = b;
    if1.in_last  = last;
    @(posedge Clk); #1;
    if1.in_valid = 1'b0;
    if1.in_last  = 1'b0;
  endtask

  // Called just after the last-beat edge: samples during QNT, then after the next edge, then takes the result.
  task automatic collect0(output logic ov_early, output logic ov, output lut_idx_t idx);
    ov_early = if0.out_valid;
    @(posedge Clk); #1;
    ov  = if0.out_valid;
    idx = if0.out_idx;
    if0.out_ready = 1'b1;
    @(posedge Clk); #1;
    if0.out_ready = 1'b0;
    $display("neuron result idx=%0d valid=%0b", idx, ov);
  endtask

  task automatic test_reset();
    #2;
    checks++; if (if0.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", if0.in_ready); end
    checks++; if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", if0.out_valid); end
    checks++; if (if0.out_idx !== 64'sd0) begin errors++; $display("FAIL rst_out_idx got=%0d exp=0", if0.out_idx); end
    checks++; if (if0.err_len !== 1'b0) begin errors++; $display("FAIL rst_err_len got=%b exp=0", if0.err_len); end
    @(posedge Clk); @(posedge Clk); #1;
    Reset = 1'b0;
  endtask

  task automatic test_single();
    logic ove, ov; lut_idx_t idx;
    beat0(16'h0100, 16'h0100, 16'h0000, 1'b1);
    checks++; if (if0.in_ready !== 1'b0) begin errors++; $display("FAIL qnt_in_ready got=%b exp=0", if0.in_ready); end
    collect0(ove, ov, idx);
    checks++; if (ove !== 1'b0) begin errors++; $display("FAIL lat_early got=%b exp=0", ove); end
    checks++; if (ov !== 1'b1) begin errors++; $display("FAIL lat_valid got=%b exp=1", ov); end
    checks++; if (idx !== 64'sd16) begin errors++; $display("FAIL single_idx got=%0d exp=16", idx); end
    checks++; if (if0.out_valid !== 1'b0 || if0.in_ready !== 1'b1) begin
      errors++; $display("FAIL single_release got=%b/%b exp=0/1", if0.out_valid, if0.in_ready); end
  endtask

  task automatic test_saturate();
    logic ove, ov; lut_idx_t idx;
    beat0(16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1); collect0(ove, ov, idx);
    checks++; if (idx !== 64'sd249) begin errors++; $display("FAIL sat_hi got=%0d exp=249", idx); end
    beat0(16'h8000, 16'h7FFF, 16'h0000, 1'b1); collect0(ove, ov, idx);
    checks++; if (idx !== -64'sd250) begin errors++; $display("FAIL sat_lo got=%0d exp=-250", idx); end
    beat0(16'h0F90, 16'h0100, 16'h0000, 1'b1); collect0(ove, ov, idx);
    checks++; if (idx !== 64'sd249) begin errors++; $display("FAIL edge_249 got=%0d exp=249", idx); end
    beat0(16'h0FA0, 16'h0100, 16'h0000, 1'b1); collect0(ove, ov, idx);
    checks++; if (idx !== 64'sd249) begin errors++; $display("FAIL edge_250 got=%0d exp=249", idx); end
    beat0(16'hF060, 16'h0100, 16'h0000, 1'b1); collect0(ove, ov, idx);
    checks++; if (idx !== -64'sd250) begin errors++; $display("FAIL edge_m250 got=%0d exp=-250", idx); end
    beat0(16'hF050, 16'h0100, 16'h0000, 1'b1); collect0(ove, ov, idx);
    checks++; if (idx !== -64'sd250) begin errors++; $display("FAIL edge_m251 got=%0d exp=-250", idx); end
  endtask

  task automatic test_multi_beat();
    logic ove, ov; lut_idx_t idx;
    beat0(16'h0100, 16'h0200, 16'h0000, 1'b0);
    beat0(16'hFF00, 16'h0100, 16'h0000, 1'b0);
    beat0(16'h0080, 16'hFC00, 16'h0000, 1'b1);
    collect0(ove, ov, idx);
    checks++; if (idx !== -64'sd16) begin errors++; $display("FAIL three_beat got=%0d exp=-16", idx); end
    beat0(16'hFFFF, 16'h0001, 16'h0000, 1'b1); collect0(ove, ov, idx);
    checks++; if (idx !== -64'sd1) begin errors++; $display("FAIL floor got=%0d exp=-1", idx); end
    beat0(16'h0000, 16'h0000, 16'h0100, 1'b0);
    beat0(16'h0000, 16'h0000, 16'h7FFF, 1'b1);
    collect0(ove, ov, idx);
    checks++; if (idx !== 64'sd16) begin errors++; $display("FAIL bias_first_only got=%0d exp=16", idx); end
  endtask

  task automatic test_back_to_back();
    logic ove, ov; lut_idx_t idx;
    beat0(16'h0200, 16'h0100, 16'h0000, 1'b1);
    @(posedge Clk); #1;
    // Junk beat offered while the result is held must be ignored.
    if0.in_valid = 1'b1; if0.in_x = 16'h7FFF; if0.in_w = 16'h7FFF; if0.in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (if0.out_valid !== 1'b1 || if0.out_idx !== 64'sd32 || if0.in_ready !== 1'b0) begin
        errors++; $display("FAIL hold_%0d got=%b/%0d/%b exp=1/32/0", i, if0.out_valid, if0.out_idx, if0.in_ready); end
      @(posedge Clk); #1;
    end
    if0.in_valid = 1'b0; if0.in_last = 1'b0;
    if0.out_ready = 1'b1;
    @(posedge Clk); #1;
    if0.out_ready = 1'b0;
    $display("held result idx=32 taken");
    checks++; if (if0.out_valid !== 1'b0 || if0.in_ready !== 1'b1) begin
      errors++; $display("FAIL hold_release got=%b/%b exp=0/1", if0.out_valid, if0.in_ready); end
    beat0(16'h0100, 16'h0100, 16'h0000, 1'b1);
    checks++; if (if0.in_ready !== 1'b0) begin errors++; $display("FAIL next_accept got=%b exp=0", if0.in_ready); end
    collect0(ove, ov, idx);
    checks++; if (idx !== 64'sd16) begin errors++; $display("FAIL next_idx got=%0d exp=16", idx); end
  endtask

  task automatic test_force_term();
    for (int k = 1; k <= 4; k++) begin
      checks++; if (if1.in_ready !== 1'b1) begin errors++; $display("FAIL ft_ready_%0d got=%b exp=1", k, if1.in_ready); end
      beat1(16'h0100, 16'h0100, (k == 1) ? 16'h0100 : 16'h0300, 1'b0);
      if (k < 4) begin
        checks++; if (if1.err_len !== 1'b0) begin errors++; $display("FAIL ft_err_early_%0d got=%b exp=0", k, if1.err_len); end
      end else begin
        checks++; if (if1.err_len !== 1'b1 || if1.in_ready !== 1'b0) begin
          errors++; $display("FAIL ft_err_pulse got=%b/%b exp=1/0", if1.err_len, if1.in_ready); end
      end
    end
    @(posedge Clk); #1;
    $display("forced neuron idx=%0d valid=%0b", if1.out_idx, if1.out_valid);
    checks++; if (if1.out_valid !== 1'b1 || if1.out_idx !== 64'sd80 || if1.err_len !== 1'b0) begin
      errors++; $display("FAIL ft_result got=%b/%0d/%b exp=1/80/0", if1.out_valid, if1.out_idx, if1.err_len); end
    if1.out_ready = 1'b1; @(posedge Clk); #1; if1.out_ready = 1'b0;
    beat1(16'h0100, 16'h0100, 16'h0200, 1'b0);
    beat1(16'h0100, 16'h0100, 16'h7FFF, 1'b1);
    checks++; if (if1.err_len !== 1'b0) begin errors++; $display("FAIL ft_no_err got=%b exp=0", if1.err_len); end
    @(posedge Clk); #1;
    $display("restarted neuron idx=%0d valid=%0b", if1.out_idx, if1.out_valid);
    checks++; if (if1.out_valid !== 1'b1 || if1.out_idx !== 64'sd64) begin
      errors++; $display("FAIL ft_restart got=%b/%0d exp=1/64", if1.out_valid, if1.out_idx); end
    if1.out_ready = 1'b1; @(posedge Clk); #1; if1.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic ove, ov; lut_idx_t idx;
    beat0(16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0);
    beat0(16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0);
    Reset = 1'b1;
    #1;
    checks++; if (if0.in_ready !== 1'b1 || if0.out_valid !== 1'b0) begin
      errors++; $display("FAIL mid_rst_hs got=%b/%b exp=1/0", if0.in_ready, if0.out_valid); end
    checks++; if (if0.out_idx !== 64'sd0 || if0.err_len !== 1'b0) begin
      errors++; $display("FAIL mid_rst_out got=%0d/%b exp=0/0", if0.out_idx, if0.err_len); end
    @(posedge Clk); #1;
    Reset = 1'b0;
    beat0(16'h0100, 16'h0100, 16'h0000, 1'b1);
    collect0(ove, ov, idx);
    checks++; if (ov !== 1'b1 || idx !== 64'sd16) begin
      errors++; $display("FAIL post_rst got=%b/%0d exp=1/16", ov, idx); end
  endtask

  initial begin
    if0.in_valid = 1'b0; if0.in_x = '0; if0.in_w = '0; if0.in_bias = '0; if0.in_last = 1'b0; if0.out_ready = 1'b0;
    if1.in_valid = 1'b0; if1.in_x = '0; if1.in_w = '0; if1.in_bias = '0; if1.in_last = 1'b0; if1.out_ready = 1'b0;
    test_reset();
    test_single();
    test_saturate();
    test_multi_beat();
    test_back_to_back();
    test_force_term();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
